// File: rtl/memtest_pkg.sv
// Shared constants and the BCD increment helper for the memtest result accumulator.
// Ports: none (package). bcd_inc returns {sat_hit, next}; next wraps 99999999 -> 0,
// and sat_hit flags that the input was already at the maximum.
package memtest_pkg;

    localparam int          BCD_DIGITS = 8;
    localparam logic [31:0] BCD_MAX    = 32'h99999999;
    localparam logic [5:0]  MARK_OFF   = 6'h3f;
    localparam logic [5:0]  POS_LAST   = 6'd62;

    typedef enum logic {
        MK_HIDDEN = 1'b0,
        MK_SWEEP  = 1'b1
    } mark_state_e;

    // Full ripple carry across all digits in one evaluation.
    function automatic logic [32:0] bcd_inc(input logic [31:0] val);
        logic [31:0] nxt;
        logic        carry;
        nxt   = val;
        carry = 1'b1;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (carry) begin
                if (val[4*d +: 4] == 4'd9) begin
                    nxt[4*d +: 4] = 4'd0;
                end else begin
                    nxt[4*d +: 4] = val[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return {(val == BCD_MAX), nxt};
    endfunction

endpackage

// File: rtl/memtest_bcd_cnt.sv
// 8-digit packed-BCD event counter with synchronous clear and optional saturation.
// Ports: clk_i, reset_i (sync, active-high), inc_i, clr_i (wins over inc_i), cnt_o.
// Latency: count visible the cycle after inc_i; no backpressure, every inc_i is taken.
module memtest_bcd_cnt
    import memtest_pkg::*;
#(
    parameter int SATURATE = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [32:0] inc_res;

    always_comb begin
        inc_res = bcd_inc(cnt_q);
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !((SATURATE != 0) && inc_res[32])) begin
            cnt_d = inc_res[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/memtest_stats.sv
// Pass/error accumulator feeding the VGA status renderer; display copies change only at vs rise.
// Ports: clk, reset, pass_stb/err_stb/clr/key_l/key_r pulses, vs in; rez1..rez4, frame_stb out.
// Latency: strobe to display <= 1 frame; no backpressure, strobes lost only when clr coincides.
module memtest_stats
    import memtest_pkg::*;
#(
    parameter int CURSOR_OFS = 3,
    parameter int SWEEP_DIV  = 4,
    parameter int SATURATE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pass_stb,
    input  logic        err_stb,
    input  logic        clr,
    input  logic        key_l,
    input  logic        key_r,
    input  logic        vs,
    output logic [31:0] rez1,
    output logic [31:0] rez2,
    output logic [5:0]  rez3,
    output logic [5:0]  rez4,
    output logic        frame_stb
);

    localparam logic [5:0] OFS6     = 6'(CURSOR_OFS);
    localparam logic [7:0] DIV_LAST = 8'(SWEEP_DIV - 1);

    logic [31:0] pass_cnt, err_cnt;

    memtest_bcd_cnt #(.SATURATE(SATURATE)) u_pass (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (pass_stb),
        .clr_i   (clr),
        .cnt_o   (pass_cnt)
    );

    memtest_bcd_cnt #(.SATURATE(SATURATE)) u_err (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (err_stb),
        .clr_i   (clr),
        .cnt_o   (err_cnt)
    );

    logic        vs_q;
    logic        vs_rise;
    logic [2:0]  digit_q, digit_d;
    mark_state_e state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  pos_q, pos_d;
    logic [5:0]  mark_q, mark_d;
    logic        advance;
    logic [31:0] rez1_q, rez2_q;
    logic [5:0]  rez3_q;
    logic        frame_q;

    assign vs_rise = vs & ~vs_q;

    // Cursor: simultaneous keys cancel; 3-bit arithmetic gives the 0<->7 wrap.
    always_comb begin
        digit_d = digit_q;
        if (key_r && !key_l) begin
            digit_d = digit_q + 3'd1;
        end else if (key_l && !key_r) begin
            digit_d = digit_q - 3'd1;
        end
    end

    // Marker FSM. The marker shows the pre-advance pos, so the first error frame shows 0.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pos_d   = pos_q;
        mark_d  = mark_q;
        advance = 1'b0;
        case (state_q)
            MK_HIDDEN: begin
                if (vs_rise && (err_cnt != '0)) begin
                    state_d = MK_SWEEP;
                    advance = 1'b1;
                end
            end
            default: begin
                // err_cnt can return to 0 here only via wrap with SATURATE=0.
                advance = vs_rise && (err_cnt != '0);
            end
        endcase
        if (advance) begin
            mark_d = pos_q;
            if (div_q == DIV_LAST) begin
                div_d = '0;
                pos_d = (pos_q == POS_LAST) ? 6'd0 : pos_q + 6'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end else if (vs_rise) begin
            mark_d = MARK_OFF;
        end
        if (clr) begin
            state_d = MK_HIDDEN;
            div_d   = '0;
            pos_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q    <= 1'b1;     // no spurious edge if vs is high leaving reset
            digit_q <= '0;
            state_q <= MK_HIDDEN;
            div_q   <= '0;
            pos_q   <= '0;
            mark_q  <= MARK_OFF;
            rez1_q  <= '0;
            rez2_q  <= '0;
            rez3_q  <= OFS6;
            frame_q <= 1'b0;
        end else begin
            vs_q    <= vs;
            digit_q <= digit_d;
            state_q <= state_d;
            div_q   <= div_d;
            pos_q   <= pos_d;
            mark_q  <= mark_d;
            frame_q <= vs_rise;
            if (vs_rise) begin
                rez1_q <= pass_cnt;
                rez2_q <= err_cnt;
                rez3_q <= {digit_q, 3'b000} + OFS6;
            end
        end
    end

    assign rez1      = rez1_q;
    assign rez2      = rez2_q;
    assign rez3      = rez3_q;
    assign rez4      = mark_q;
    assign frame_stb = frame_q;

endmodule

// File: tb/tb_memtest_stats.sv
// Scoreboard bench for memtest_stats: two instances (saturating / wrapping) share stimulus.
// Expected frames are pushed when a vs rise is driven; a monitor pops on every frame_stb.
module tb_memtest_stats;

    logic clk = 1'b0;
    logic reset, pass_stb, err_stb, clr, key_l, key_r, vs;
    logic [31:0] rez1_a, rez2_a, rez1_b, rez2_b;
    logic [5:0]  rez3_a, rez4_a, rez3_b, rez4_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    memtest_stats #(.CURSOR_OFS(3), .SWEEP_DIV(4), .SATURATE(1)) dut_a (
        .clk(clk), .reset(reset), .pass_stb(pass_stb), .err_stb(err_stb), .clr(clr),
        .key_l(key_l), .key_r(key_r), .vs(vs),
        .rez1(rez1_a), .rez2(rez2_a), .rez3(rez3_a), .rez4(rez4_a), .frame_stb(fs_a)
    );

    memtest_stats #(.CURSOR_OFS(5), .SWEEP_DIV(3), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .pass_stb(pass_stb), .err_stb(err_stb), .clr(clr),
        .key_l(key_l), .key_r(key_r), .vs(vs),
        .rez1(rez1_b), .rez2(rez2_b), .rez3(rez3_b), .rez4(rez4_b), .frame_stb(fs_b)
    );

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [5:0]  r3;
        logic [5:0]  r4;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int vectors = 0;
    int errors  = 0;

    // Reference model state: plain decimal counts, cursor digit, frames seen with errors.
    int unsigned m_pass[2];
    int unsigned m_err[2];
    int unsigned m_frames[2];
    int          m_dig;
    logic        m_vs;

    function automatic int ofs_of(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int unsigned bump(input int unsigned v, input bit sat);
        if (v == 99999999) return sat ? v : 0;
        return v + 1;
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model of one clock edge given the inputs applied before it.
    task automatic model_cycle(input logic p, input logic e, input logic c,
                               input logic kl, input logic kr, input logic v);
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            if (v && !m_vs) begin
                x.r1 = to_bcd(m_pass[i]);
                x.r2 = to_bcd(m_err[i]);
                x.r3 = 6'(m_dig * 8 + ofs_of(i));
                if (m_err[i] == 0) begin
                    x.r4 = 6'h3f;
                end else begin
                    x.r4 = 6'((m_frames[i] / div_of(i)) % 63);
                    m_frames[i]++;
                end
                if (i == 0) q_a.push_back(x);
                else        q_b.push_back(x);
            end
            if (c) begin
                m_pass[i]   = 0;
                m_err[i]    = 0;
                m_frames[i] = 0;
            end else begin
                if (p) m_pass[i] = bump(m_pass[i], i == 0);
                if (e) m_err[i]  = bump(m_err[i], i == 0);
            end
        end
        m_vs = v;
        if (kr && !kl)      m_dig = (m_dig + 1) % 8;
        else if (kl && !kr) m_dig = (m_dig + 7) % 8;
    endtask

    task automatic step(input logic p, input logic e, input logic c,
                        input logic kl, input logic kr, input logic v);
        @(negedge clk);
        pass_stb = p; err_stb = e; clr = c; key_l = kl; key_r = kr; vs = v;
        model_cycle(p, e, c, kl, kr, v);
    endtask

    function automatic logic rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // One vs-high cycle (strobes allowed, never clr) then 7 low cycles.
    task automatic run_frame(input int pp, input int ep, input int cp, input int kp);
        step(rnd(pp), rnd(ep), 1'b0, rnd(kp), rnd(kp), 1'b1);
        repeat (7) step(rnd(pp), rnd(ep), rnd(cp), rnd(kp), rnd(kp), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        reset = 1'b1; pass_stb = 1'b1; err_stb = 1'b1; clr = 1'b0;
        key_l = 1'b1; key_r = 1'b0; vs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_pass[i] = 0; m_err[i] = 0; m_frames[i] = 0;
        end
        m_dig = 0;
        m_vs  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rez1", rez1_a, 32'd0);
        chk("rst_rez2", rez2_a, 32'd0);
        chk("rst_rez3_a", {26'd0, rez3_a}, 32'd3);
        chk("rst_rez3_b", {26'd0, rez3_b}, 32'd5);
        chk("rst_rez4", {26'd0, rez4_a}, 32'h3f);
        chk("rst_fstb", {31'd0, fs_a}, 32'd0);
        // Leave reset with vs still high: no frame may be produced.
        reset = 1'b0; pass_stb = 1'b0; err_stb = 1'b0; key_l = 1'b0;
        model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic mon(input int i, input logic fs, input exp_t act);
        exp_t x;
        if (fs === 1'b1) begin
            vectors++;
            if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
                errors++;
                $display("FAIL frame_%0d: frame_stb with no expected frame, rez=%h", i, act);
            end else begin
                if (i == 0) x = q_a.pop_front();
                else        x = q_b.pop_front();
                if (act !== x) begin
                    errors++;
                    $display("FAIL frame_%0d: got rez1=%h rez2=%h rez3=%0d rez4=%h expected rez1=%h rez2=%h rez3=%0d rez4=%h",
                             i, act.r1, act.r2, act.r3, act.r4, x.r1, x.r2, x.r3, x.r4);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, fs_a, {rez1_a, rez2_a, rez3_a, rez4_a});
            mon(1, fs_b, {rez1_b, rez2_b, rez3_b, rez4_b});
        end
    end

    initial begin
        reset = 1'b1; pass_stb = 1'b0; err_stb = 1'b0; clr = 1'b0;
        key_l = 1'b0; key_r = 1'b0; vs = 1'b0;
        m_vs = 1'b1; m_dig = 0;

        // 12 passes then one frame.
        do_reset();
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t1_rez1", rez1_a, 32'h00000012);
        chk("t1_rez2", rez2_a, 32'h00000000);

        // Multi-digit carry 999 -> 1000.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (999) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t2_rez1_999", rez1_a, 32'h00000999);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t2_rez1_1000", rez1_a, 32'h00001000);

        // Saturate vs wrap at 99999999 (counters preset by force).
        @(negedge clk);
        pass_stb = 1'b0; err_stb = 1'b0; clr = 1'b0; key_l = 1'b0; key_r = 1'b0; vs = 1'b0;
        force dut_a.u_pass.cnt_q = 32'h99999999;
        force dut_b.u_pass.cnt_q = 32'h99999999;
        model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        release dut_a.u_pass.cnt_q;
        release dut_b.u_pass.cnt_q;
        model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_pass[0] = 99999999;
        m_pass[1] = 99999999;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t3_sat_rez1", rez1_a, 32'h99999999);
        chk("t3_wrap_rez1", rez1_b, 32'h00000000);

        // Strobes in the edge cycle appear one frame later; clr beats err_stb.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_edge_rez1", rez1_a, 32'h00000000);
        chk("t4_edge_rez2", rez2_a, 32'h00000000);
        run_frame(0, 0, 0, 0);
        chk("t4_next_rez1", rez1_a, 32'h00000001);
        chk("t4_next_rez2", rez2_a, 32'h00000001);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t4_clr_rez2", rez2_a, 32'h00000000);

        // Cursor wrap and key cancel.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t5_left_a", {26'd0, rez3_a}, 32'd59);
        chk("t5_left_b", {26'd0, rez3_b}, 32'd61);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t5_right2_a", {26'd0, rez3_a}, 32'd11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t5_both_a", {26'd0, rez3_a}, 32'd11);

        // Activity marker sweep incl. 62 -> 0 wrap, then clr hides it.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t6_first_a", {26'd0, rez4_a}, 32'd0);
        repeat (259) run_frame(0, 0, 0, 0);
        chk("t6_wrap_a", {26'd0, rez4_a}, 32'd1);
        chk("t6_wrap_b", {26'd0, rez4_b}, 32'd23);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0);
        chk("t6_clr_a", {26'd0, rez4_a}, 32'h3f);

        // Random traffic against the model.
        repeat (200) run_frame(30, 25, 3, 15);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("end_queue_a", 32'(q_a.size()), 32'd0);
        chk("end_queue_b", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
